// File: rtl/rw_handshake_checker.sv
// rw_handshake_checker: passive per-channel read/write handshake checker.
// Optional macro CHK_SVA_EN adds one concurrent assertion per rule per channel.
module rw_handshake_checker #(
    parameter int  NCH     = 4,
    parameter int  TIMEOUT = 16,
    parameter int  CNT_W   = 8,
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   read,
    input  logic [NCH-1:0]   write,
    input  logic [NCH-1:0]   ack,
    input  logic             clr,
    output logic [NCH-1:0]   err_vec,
    output logic [CNT_W-1:0] err_count,
    output logic             first_vld,
    output logic [CH_W-1:0]  first_ch,
    output logic [2:0]       first_code
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    localparam logic [2:0]       E_NONE     = 3'd0;
    localparam logic [2:0]       E_CONFLICT = 3'd1;
    localparam logic [2:0]       E_SPURIOUS = 3'd2;
    localparam logic [2:0]       E_DROP     = 3'd3;
    localparam logic [2:0]       E_TIMEOUT  = 3'd4;
    localparam logic [15:0]      TMO        = 16'(TIMEOUT);
    localparam int               SUM_W      = CNT_W + 6;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t             state_q [NCH];
    state_t             state_d [NCH];
    logic [15:0]        wcnt_q  [NCH];
    logic [15:0]        wcnt_d  [NCH];
    logic [2:0]         code    [NCH];
    logic [NCH-1:0]     held;
    logic [NCH-1:0]     err;
    logic [5:0]         n_err;
    logic [SUM_W-1:0]   sum;
    logic [CNT_W-1:0]   cnt_d;
    logic [CH_W-1:0]    f_ch;
    logic [2:0]         f_code;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            wcnt_d[i]  = wcnt_q[i];
            code[i]    = E_NONE;
            held[i]    = (state_q[i] == RD_WAIT) ? read[i] : write[i];
            unique case (state_q[i])
                IDLE: begin
                    if (read[i] && write[i]) begin
                        code[i] = E_CONFLICT;
                    end else if (ack[i]) begin
                        if (!read[i] && !write[i]) code[i] = E_SPURIOUS;
                    end else if (read[i]) begin
                        state_d[i] = RD_WAIT;
                        wcnt_d[i]  = 16'd1;
                    end else if (write[i]) begin
                        state_d[i] = WR_WAIT;
                        wcnt_d[i]  = 16'd1;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    state_d[i] = IDLE;
                    wcnt_d[i]  = '0;
                    if (read[i] && write[i]) begin
                        code[i] = E_CONFLICT;
                    end else if (!ack[i]) begin
                        if (!held[i]) begin
                            code[i] = E_DROP;
                        end else if (wcnt_q[i] == TMO) begin
                            code[i] = E_TIMEOUT;
                        end else begin
                            state_d[i] = state_q[i];
                            wcnt_d[i]  = wcnt_q[i] + 16'd1;
                        end
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    wcnt_d[i]  = '0;
                end
            endcase
        end
    end

    always_comb begin
        err = '0;
        for (int i = 0; i < NCH; i++) err[i] = (code[i] != E_NONE);
    end

    // Lowest-index channel wins the first-error capture.
    always_comb begin
        n_err  = '0;
        f_ch   = '0;
        f_code = E_NONE;
        for (int i = 0; i < NCH; i++) n_err = n_err + 6'(err[i]);
        for (int i = NCH - 1; i >= 0; i--) begin
            if (err[i]) begin
                f_ch   = CH_W'(i);
                f_code = code[i];
            end
        end
        sum   = SUM_W'(err_count) + SUM_W'(n_err);
        cnt_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                wcnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                wcnt_q[i]  <= wcnt_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_vec    <= '0;
            err_count  <= '0;
            first_vld  <= 1'b0;
            first_ch   <= '0;
            first_code <= '0;
        end else if (clr) begin
            err_vec    <= '0;
            err_count  <= '0;
            first_vld  <= 1'b0;
            first_ch   <= '0;
            first_code <= '0;
        end else begin
            err_vec   <= err_vec | err;
            err_count <= cnt_d;
            if (!first_vld && (|err)) begin
                first_vld  <= 1'b1;
                first_ch   <= f_ch;
                first_code <= f_code;
            end
        end
    end

`ifdef CHK_SVA_EN
    for (genvar g = 0; g < NCH; g++) begin : g_sva
        a_conflict: assert property (@(posedge clk) disable iff (!rst_n)
            code[g] != E_CONFLICT)
            else $error("ch %0d code %0d", g, E_CONFLICT);
        a_spurious: assert property (@(posedge clk) disable iff (!rst_n)
            code[g] != E_SPURIOUS)
            else $error("ch %0d code %0d", g, E_SPURIOUS);
        a_drop: assert property (@(posedge clk) disable iff (!rst_n)
            code[g] != E_DROP)
            else $error("ch %0d code %0d", g, E_DROP);
        a_timeout: assert property (@(posedge clk) disable iff (!rst_n)
            code[g] != E_TIMEOUT)
            else $error("ch %0d code %0d", g, E_TIMEOUT);
    end
`endif

endmodule

// File: tb/tb_rw_handshake_checker.sv
// Scoreboard bench for rw_handshake_checker: directed scenarios then
// randomized per-channel traffic against a transaction-level reference model.
module tb_rw_handshake_checker;

    localparam int NCH  = 4;
    localparam int TO   = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    read  = '0;
    logic [3:0]    write = '0;
    logic [3:0]    ack   = '0;
    logic          clr   = 1'b0;
    logic [3:0]    err_vec;
    logic [CW-1:0] err_count;
    logic          first_vld;
    logic [1:0]    first_ch;
    logic [2:0]    first_code;

    always #5 clk = ~clk;

    rw_handshake_checker #(
        .NCH(NCH),
        .TIMEOUT(TO),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .read(read),
        .write(write),
        .ack(ack),
        .clr(clr),
        .err_vec(err_vec),
        .err_count(err_count),
        .first_vld(first_vld),
        .first_ch(first_ch),
        .first_code(first_code)
    );

    typedef struct packed {
        logic [3:0]    vec;
        logic [CW-1:0] cnt;
        logic          fv;
        logic [1:0]    fch;
        logic [2:0]    fcode;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    bit   running = 1'b0;

    // Reference model: outstanding request kind and the cycle it started.
    int         pend  [NCH];
    int         start [NCH];
    int         cyc = 0;
    logic [3:0] m_vec = '0;
    int         m_cnt = 0;
    bit         m_fv = 1'b0;
    int         m_fch = 0;
    int         m_fcode = 0;

    int hold [NCH];
    int kind [NCH];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.vec   = m_vec;
        e.cnt   = CW'(m_cnt);
        e.fv    = m_fv;
        e.fch   = 2'(m_fch);
        e.fcode = 3'(m_fcode);
        sb.push_back(e);
        running = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) pend[i] = 0;
        m_vec = '0;
        m_cnt = 0;
        m_fv = 1'b0;
        m_fch = 0;
        m_fcode = 0;
    endtask

    task automatic model_cycle();
        int c [NCH];
        int n = 0;
        bit got = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            bit r = read[i];
            bit w = write[i];
            bit a = ack[i];
            bit h;
            c[i] = 0;
            if (pend[i] == 0) begin
                if (r && w) c[i] = 1;
                else if (a && !r && !w) c[i] = 2;
                else if ((r || w) && !a) begin
                    pend[i]  = r ? 1 : 2;
                    start[i] = cyc;
                end
            end else begin
                h = (pend[i] == 1) ? r : w;
                if (r && w) begin
                    c[i] = 1;
                    pend[i] = 0;
                end else if (a) begin
                    pend[i] = 0;
                end else if (!h) begin
                    c[i] = 3;
                    pend[i] = 0;
                end else if (cyc - start[i] == TO) begin
                    c[i] = 4;
                    pend[i] = 0;
                end
            end
        end
        if (clr) begin
            m_vec = '0;
            m_cnt = 0;
            m_fv = 1'b0;
            m_fch = 0;
            m_fcode = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (c[i] != 0) begin
                    m_vec[i] = 1'b1;
                    n++;
                    if (!m_fv && !got) begin
                        got = 1'b1;
                        m_fch = i;
                        m_fcode = c[i];
                    end
                end
            end
            if (got) m_fv = 1'b1;
            m_cnt = (m_cnt + n > CMAX) ? CMAX : m_cnt + n;
        end
        cyc++;
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] w,
                        input logic [3:0] a, input logic c);
        @(negedge clk);
        rst_n = 1'b1;
        read  = r;
        write = w;
        ack   = a;
        clr   = c;
        model_cycle();
        push_exp();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        read  = '0;
        write = '0;
        ack   = '0;
        clr   = 1'b0;
        model_reset();
        #1;
        chk("rst_err_vec", 32'(err_vec), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_first_vld", 32'(first_vld), 0);
        chk("rst_first_ch", 32'(first_ch), 0);
        chk("rst_first_code", 32'(first_code), 0);
        push_exp();
        repeat (n - 1) begin
            @(negedge clk);
            push_exp();
        end
    endtask

    task automatic rand_cycle();
        logic [3:0] r = '0;
        logic [3:0] w = '0;
        logic [3:0] a = '0;
        logic c;
        for (int i = 0; i < NCH; i++) begin
            if (hold[i] == 0 && $urandom_range(2) == 0) begin
                kind[i] = $urandom_range(1);
                hold[i] = $urandom_range(1, TO + 2);
            end
            if (hold[i] > 0) begin
                if (kind[i] == 0) r[i] = 1'b1;
                else w[i] = 1'b1;
                if (hold[i] == 1 && $urandom_range(3) != 0) a[i] = 1'b1;
                if ($urandom_range(29) == 0) begin
                    r[i] = 1'b0;
                    w[i] = 1'b0;
                end
                hold[i]--;
            end
            if ($urandom_range(39) == 0) begin
                r[i] = 1'b1;
                w[i] = 1'b1;
            end
            if ($urandom_range(39) == 0) a[i] = 1'b1;
        end
        c = ($urandom_range(11) == 0);
        step(r, w, a, c);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("err_vec", 32'(err_vec), 32'(mon_e.vec));
            chk("err_count", 32'(err_count), 32'(mon_e.cnt));
            chk("first_vld", 32'(first_vld), 32'(mon_e.fv));
            chk("first_ch", 32'(first_ch), 32'(mon_e.fch));
            chk("first_code", 32'(first_code), 32'(mon_e.fcode));
        end else if (running) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: no expected entry at %0t", $time);
        end
    end

    initial begin
        for (int i = 0; i < NCH; i++) begin
            hold[i] = 0;
            kind[i] = 0;
            pend[i] = 0;
            start[i] = 0;
        end
        do_reset(3);
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // zero-error read on ch0, acked in cycle 2
        step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 4'b0001, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        settle();
        chk("t1_count", 32'(err_count), 0);
        chk("t1_vec", 32'(err_vec), 0);

        // conflict on ch1
        step(4'b0010, 4'b0010, 4'b0000, 1'b0);
        settle();
        chk("t2_vec", 32'(err_vec), 32'b0010);
        chk("t2_count", 32'(err_count), 1);
        chk("t2_first_ch", 32'(first_ch), 1);
        chk("t2_first_code", 32'(first_code), 1);
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // ch2 write timeout, then ack in the last legal cycle
        repeat (5) step(4'b0000, 4'b0100, 4'b0000, 1'b0);
        settle();
        chk("t3_vec", 32'(err_vec), 32'b0100);
        chk("t3_count", 32'(err_count), 1);
        chk("t3_first_code", 32'(first_code), 4);
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);
        repeat (4) step(4'b0000, 4'b0100, 4'b0000, 1'b0);
        step(4'b0000, 4'b0100, 4'b0100, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        settle();
        chk("t3b_count", 32'(err_count), 0);

        // ch3 drop together with ch0 spurious ack
        step(4'b1000, 4'b0000, 4'b0000, 1'b0);
        step(4'b1000, 4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 4'b0001, 1'b0);
        settle();
        chk("t4_count", 32'(err_count), 2);
        chk("t4_first_ch", 32'(first_ch), 0);
        chk("t4_first_code", 32'(first_code), 2);
        chk("t4_vec", 32'(err_vec), 32'b1001);
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // counter saturation, then clr beating a new error
        repeat (5) step(4'b0001, 4'b0001, 4'b0000, 1'b0);
        settle();
        chk("t5_count_sat", 32'(err_count), CMAX);
        step(4'b0010, 4'b0010, 4'b0000, 1'b1);
        settle();
        chk("t5_clr_vec", 32'(err_vec), 0);
        chk("t5_clr_count", 32'(err_count), 0);
        chk("t5_clr_vld", 32'(first_vld), 0);
        chk("t5_clr_code", 32'(first_code), 0);

        // reset while ch0 waits with wcnt=3, then a clean transfer
        step(4'b0101, 4'b0100, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        do_reset(2);
        step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 4'b0001, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        settle();
        chk("t6_count", 32'(err_count), 0);
        chk("t6_vec", 32'(err_vec), 0);

        for (int k = 0; k < 4000; k++) begin
            if (k % 700 == 350) do_reset(2);
            rand_cycle();
        end
        settle();
        running = 1'b0;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rw_handshake_checker.md
# rw_handshake_checker

Parametrised, synthesizable protocol checker for NCH independent read/write request channels with per-channel acknowledge. Each channel runs a small handshake FSM that flags read/write conflicts, requests dropped before acknowledge, acknowledges with no request outstanding, and acknowledge timeouts. It aggregates errors into sticky flags, a saturating counter and a first-error capture. It sits passively beside bus masters/slaves in simulation and in silicon and never drives the bus.

## Interface
- NCH, 4: number of monitored channels (1..32)
- TIMEOUT, 16: maximum cycles from request start to acknowledge (2..2^16-1)
- CNT_W, 8: width of the total error counter
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- read  in  NCH  per-channel read request (level, held until ack)
- write  in  NCH  per-channel write request (level, held until ack)
- ack  in  NCH  per-channel acknowledge, single-cycle pulse
- clr  in  1  synchronous clear of all error reporting state
- err_vec  out  NCH  sticky per-channel error flag
- err_count  out  CNT_W  saturating total error count
- first_vld  out  1  first-error capture valid
- first_ch  out  $clog2(NCH) (min 1)  channel of first error
- first_code  out  3  code of first error: 1 CONFLICT, 2 SPURIOUS, 3 DROP, 4 TIMEOUT

## Operation
- Per-channel FSM states: IDLE, RD_WAIT, WR_WAIT; wait counter wcnt, 16 bits.
- IDLE: read&write -> CONFLICT, stay IDLE. ack with no read/write -> SPURIOUS. read (or write) with ack same cycle -> zero-wait transfer, stay IDLE. read (or write) without ack -> RD_WAIT (or WR_WAIT), wcnt=1.
- RD_WAIT (WR_WAIT symmetric): evaluated in priority order.
  - read&write -> CONFLICT, go IDLE.
  - ack -> transfer done, go IDLE; read low in the same cycle as ack is legal.
  - read low (no ack) -> DROP, go IDLE.
  - wcnt==TIMEOUT -> TIMEOUT, go IDLE.
  - Otherwise wcnt+1.
- Acknowledge is legal in cycles 0..TIMEOUT, where cycle 0 is the first cycle the request is high.
- A request still high after an error that returned the FSM to IDLE is treated as a new request on the next cycle.
- At most one error per channel per cycle; code follows the priority above.
- err_vec[i] set on any error on channel i; stays set until clr or reset.
- err_count += number of channels erroring this cycle; saturates at 2^CNT_W-1, never wraps.
- First capture loads on the first error while first_vld=0. Lowest-index channel wins on simultaneous errors. The capture then freezes.
- clr: clears err_vec, err_count, first_vld/ch/code; clr wins over errors in the same cycle (those errors are discarded from reporting). FSM states and wcnt are unaffected by clr.

## Timing
- All outputs registered. An error detected on the inputs sampled at edge N is visible after edge N.
- Reset (async assert, sync deassert recommended externally): all FSMs IDLE, wcnt=0, err_vec=0, err_count=0, first_vld=0, first_ch=0, first_code=0.
- Reset mid-transaction abandons the wait silently; no error is reported for it.
- Inputs are sampled only at rising clk; glitches between edges are ignored.

## Configuration
- CHK_SVA_EN defined: the block additionally contains one concurrent assertion per rule per channel (clocked on clk, disabled while !rst_n). Each assertion issues $error with channel index and code at the same cycle the counter updates. Assertions are not gated by clr.
- Not defined: no assertion constructs are compiled; the counters and flags are the only reporting. RTL behaviour is identical in both cases.

## Test plan
- NCH=4, TIMEOUT=4: ch0 read high cycles 0-2, ack at cycle 2 -> no error, err_count=0, ch0 IDLE at cycle 3.
- ch1 read&write both high at cycle 5 -> err_vec=4'b0010, err_count=1, first_ch=1, first_code=1 after that edge.
- ch2 write high from cycle 0, no ack -> TIMEOUT flagged at cycle 4 sample, visible after edge 4; err_count+1. Ack at cycle 4 instead -> no error.
- ch3 read high cycles 0-1, dropped at cycle 2 without ack -> DROP; simultaneous SPURIOUS on ch0 the same cycle -> err_count+2, first_ch=0, first_code=2.
- CNT_W=2: drive 5 CONFLICTs -> err_count stops at 3; then clr asserted together with a new error -> all outputs 0 next cycle.
- Assert rst_n low during RD_WAIT on ch0 with wcnt=3 -> outputs zero immediately; after release with read high and ack on cycle 1 -> no error.
